// File: rtl/coherence_ctrl.sv
// Shares one RAM port between two icaches and two dcaches and sequences MSI snoops between the dcaches.
// Latency: grant one cycle after a request is seen in IDLE, then one RAM access per word. Backpressure: ramstate stalls the owner, everyone else waits.
// There is no snoop timeout; the snooper must answer via cctrans.
module coherence_ctrl #(
    parameter int CPUS = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [CPUS-1:0]            iREN,
    input  logic [CPUS-1:0][31:0]      iaddr,
    output logic [CPUS-1:0]            iwait,
    output logic [CPUS-1:0][31:0]      iload,
    input  logic [CPUS-1:0]            dREN,
    input  logic [CPUS-1:0]            dWEN,
    input  logic [CPUS-1:0][31:0]      daddr,
    input  logic [CPUS-1:0][31:0]      dstore,
    output logic [CPUS-1:0]            dwait,
    output logic [CPUS-1:0][31:0]      dload,
    input  logic [CPUS-1:0]            cctrans,
    input  logic [CPUS-1:0]            ccwrite,
    output logic [CPUS-1:0]            ccwait,
    output logic [CPUS-1:0]            ccinv,
    output logic [CPUS-1:0][31:0]      ccsnoopaddr,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [31:0]                ramaddr,
    output logic [31:0]                ramstore,
    input  logic [31:0]                ramload,
    input  logic [1:0]                 ramstate
);

    typedef enum logic [2:0] {IDLE, IFETCH, DWB, SNOOP, C2C, LD, ACK} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t          state;
    state_t          grant_state;
    logic            req;
    logic            last;
    logic            snp;
    logic            access;
    logic            word1;
    logic            grant;
    logic [CPUS-1:0] wb_vec;
    logic [CPUS-1:0] sel_vec;

    assign snp    = ~req;
    assign access = (ramstate == RAM_ACCESS);
    assign word1  = daddr[req][2];

    // Writebacks beat coherent requests, which beat fetches; ties go to the core not served last.
    always_comb begin
        wb_vec = dWEN & ~cctrans;
        if (|wb_vec) begin
            sel_vec     = wb_vec;
            grant_state = DWB;
        end else if (|cctrans) begin
            sel_vec     = cctrans;
            grant_state = SNOOP;
        end else if (|iREN) begin
            sel_vec     = iREN;
            grant_state = IFETCH;
        end else begin
            sel_vec     = '0;
            grant_state = IDLE;
        end
        grant = (sel_vec == 2'b11) ? ~last : sel_vec[1];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            last  <= 1'b1;
            req   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|sel_vec) begin
                        state <= grant_state;
                        req   <= grant;
                        last  <= grant;
                    end
                end
                IFETCH: if (access) state <= IDLE;
                DWB, C2C, LD: if (access && word1) state <= IDLE;
                SNOOP: begin
                    if (cctrans[snp]) begin
                        if (ccwrite[snp])
                            state <= C2C;
                        else if (!dREN[req] && !dWEN[req])
                            state <= ACK;
                        else
                            state <= LD;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = iaddr[req];
                iload[req] = ramload;
                iwait[req] = ~access;
            end
            DWB: begin
                ramWEN     = 1'b1;
                ramaddr    = daddr[req];
                ramstore   = dstore[req];
                dwait[req] = ~access;
            end
            SNOOP: begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = ccwrite[req];
                ccsnoopaddr[snp] = daddr[req];
            end
            C2C: begin
                // The Modified line goes to the requester and to memory in the same cycle.
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = ccwrite[req];
                ccsnoopaddr[snp] = daddr[req];
                dload[req]       = dstore[snp];
                ramWEN           = 1'b1;
                ramaddr          = daddr[req];
                ramstore         = dstore[snp];
                dwait[req]       = ~access;
            end
            LD: begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = ccwrite[req];
                ccsnoopaddr[snp] = daddr[req];
                ramREN           = 1'b1;
                ramaddr          = daddr[req];
                dload[req]       = ramload;
                dwait[req]       = ~access;
            end
            ACK: begin
                dwait[req]       = 1'b0;
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = 1'b1;
                ccsnoopaddr[snp] = daddr[req];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Bench for coherence_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the bus controller.
module tb_coherence_ctrl;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 1'b0;

    always #5 CLK = ~CLK;

    coherence_ctrl #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    // RAM: reads return a fixed function of the address; writes are recorded on ACCESS.
    assign ramload = ramaddr ^ 32'hA5A5_0000;
    logic [31:0] mem [0:4095];
    always @(posedge CLK)
        if (nRST && ramWEN && ramstate == 2'd2) mem[ramaddr[13:2]] <= ramstore;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Transaction-level model: which job is running and for whom.
    localparam int J_NONE = 0, J_FETCH = 1, J_WB = 2, J_SNOOP = 3, J_C2C = 4, J_LD = 5, J_ACK = 6;
    int job  = J_NONE;
    int own  = 0;
    int lstc = 1;

    function automatic int pick(input logic [1:0] want);
        if (want == 2'b11) return 1 - lstc;
        return want[1] ? 1 : 0;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            job <= J_NONE; own <= 0; lstc <= 1;
        end else if (job == J_NONE) begin
            if ((dWEN & ~cctrans) != 0) begin
                job <= J_WB; own <= pick(dWEN & ~cctrans); lstc <= pick(dWEN & ~cctrans);
            end else if (cctrans != 0) begin
                job <= J_SNOOP; own <= pick(cctrans); lstc <= pick(cctrans);
            end else if (iREN != 0) begin
                job <= J_FETCH; own <= pick(iREN); lstc <= pick(iREN);
            end
        end else if (job == J_FETCH) begin
            if (ramstate == 2'd2) job <= J_NONE;
        end else if (job == J_SNOOP) begin
            if (cctrans[1-own])
                job <= ccwrite[1-own] ? J_C2C : ((dREN[own] || dWEN[own]) ? J_LD : J_ACK);
        end else if (job == J_ACK) begin
            job <= J_NONE;
        end else begin
            // Two-word jobs finish on the access of the second word.
            if (ramstate == 2'd2 && daddr[own][2]) job <= J_NONE;
        end
    end

    task automatic check_outputs();
        logic [1:0]  e_iw, e_dw, e_cw, e_ci;
        logic        e_ren, e_wen, acc;
        logic [31:0] e_addr, e_store;
        int s;
        s = 1 - own;
        acc = (ramstate == 2'd2);
        e_iw = 2'b11; e_dw = 2'b11; e_cw = 2'b00; e_ci = 2'b00;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        case (job)
            J_NONE: begin
                chk("idle_iload", iload[0] | iload[1], 0);
                chk("idle_dload", dload[0] | dload[1], 0);
                chk("idle_snoopaddr", ccsnoopaddr[0] | ccsnoopaddr[1], 0);
            end
            J_FETCH: begin
                e_ren = 1'b1; e_addr = iaddr[own]; e_iw[own] = !acc;
                chk("fetch_iload", iload[own], iaddr[own] ^ 32'hA5A5_0000);
            end
            J_WB: begin
                e_wen = 1'b1; e_addr = daddr[own]; e_store = dstore[own]; e_dw[own] = !acc;
            end
            J_SNOOP: begin
                e_cw[s] = 1'b1; e_ci[s] = ccwrite[own];
                chk("snoop_addr", ccsnoopaddr[s], daddr[own]);
            end
            J_C2C: begin
                e_cw[s] = 1'b1; e_ci[s] = ccwrite[own];
                e_wen = 1'b1; e_addr = daddr[own]; e_store = dstore[s]; e_dw[own] = !acc;
                chk("c2c_dload", dload[own], dstore[s]);
                chk("c2c_snoopaddr", ccsnoopaddr[s], daddr[own]);
            end
            J_LD: begin
                e_cw[s] = 1'b1; e_ci[s] = ccwrite[own];
                e_ren = 1'b1; e_addr = daddr[own]; e_dw[own] = !acc;
                chk("ld_dload", dload[own], daddr[own] ^ 32'hA5A5_0000);
            end
            default: begin
                e_dw[own] = 1'b0; e_cw[s] = 1'b1; e_ci[s] = 1'b1;
            end
        endcase
        chk("iwait", 32'(iwait), 32'(e_iw));
        chk("dwait", 32'(dwait), 32'(e_dw));
        chk("ccwait", 32'(ccwait), 32'(e_cw));
        chk("ccinv", 32'(ccinv), 32'(e_ci));
        chk("ramREN", 32'(ramREN), 32'(e_ren));
        chk("ramWEN", 32'(ramWEN), 32'(e_wen));
        if (e_ren || e_wen || job == J_NONE) chk("ramaddr", ramaddr, e_addr);
        if (e_wen || job == J_NONE) chk("ramstore", ramstore, e_store);
    endtask

    always @(negedge CLK) if (run_chk) check_outputs();

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramstate = 2'd2;
    endtask

    initial begin
        nRST = 1'b0;
        quiet();
        run_chk = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_iwait", 32'(iwait), 3);
        chk("rst_dwait", 32'(dwait), 3);
        chk("rst_ccwait", 32'(ccwait), 0);
        chk("rst_ram", 32'({ramREN, ramWEN}), 0);

        // Icache tie: core 0 first, then alternation.
        step(); nRST = 1'b1; iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200;
        @(negedge CLK); chk("t1_idle_iwait", 32'(iwait), 3);
        step(); @(negedge CLK);
        chk("t1_c0_iwait", 32'(iwait), 2); chk("t1_c0_iload", iload[0], 32'hA5A5_0100);
        step(); @(negedge CLK); chk("t1_gap_iwait", 32'(iwait), 3);
        step(); @(negedge CLK);
        chk("t1_c1_iwait", 32'(iwait), 1); chk("t1_c1_iload", iload[1], 32'hA5A5_0200);
        step(); step(); @(negedge CLK); chk("t1_alt_iwait", 32'(iwait), 2);
        step(); quiet();

        // Writeback beats a concurrent fetch.
        step(); dWEN[0] = 1'b1; daddr[0] = 32'h1000; dstore[0] = 32'h1111_1111;
        iREN[1] = 1'b1; iaddr[1] = 32'h300;
        step(); @(negedge CLK);
        chk("t2_w0_addr", ramaddr, 32'h1000); chk("t2_w0_dwait", 32'(dwait), 2);
        chk("t2_w0_iwait", 32'(iwait), 3);
        step(); daddr[0] = 32'h1004; dstore[0] = 32'h2222_2222;
        @(negedge CLK); chk("t2_w1_store", ramstore, 32'h2222_2222); chk("t2_w1_iwait", 32'(iwait), 3);
        step(); dWEN[0] = 1'b0;
        @(negedge CLK);
        chk("t2_mem0", mem[12'h400], 32'h1111_1111); chk("t2_mem1", mem[12'h401], 32'h2222_2222);
        step(); @(negedge CLK); chk("t2_fetch_iwait", 32'(iwait), 1);
        step(); quiet();

        // BusRd with a clean snooper: data from RAM.
        step(); dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h2000;
        step(); cctrans[1] = 1'b1;
        @(negedge CLK);
        chk("t3_ccwait", 32'(ccwait), 2); chk("t3_ccinv", 32'(ccinv), 0);
        chk("t3_snoopaddr", ccsnoopaddr[1], 32'h2000);
        step(); @(negedge CLK);
        chk("t3_w0_dload", dload[0], 32'hA5A5_2000); chk("t3_w0_ren", 32'(ramREN), 1);
        step(); daddr[0] = 32'h2004; cctrans[1] = 1'b0;
        @(negedge CLK); chk("t3_w1_dload", dload[0], 32'hA5A5_2004); chk("t3_w1_ccwait", 32'(ccwait), 2);
        step(); quiet();

        // BusRdX hitting a Modified line: cache-to-cache with writeback.
        step(); dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h3000;
        step(); cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dstore[0] = 32'hDEAD_BEEF;
        @(negedge CLK); chk("t4_ccinv", 32'(ccinv), 1);
        step(); @(negedge CLK); chk("t4_w0_dload", dload[1], 32'hDEAD_BEEF);
        step(); daddr[1] = 32'h3004; dstore[0] = 32'hCAFE_F00D;
        @(negedge CLK); chk("t4_w1_dload", dload[1], 32'hCAFE_F00D);
        step(); quiet();
        @(negedge CLK);
        chk("t4_mem0", mem[12'hC00], 32'hDEAD_BEEF); chk("t4_mem1", mem[12'hC01], 32'hCAFE_F00D);

        // Upgrade: one-cycle acknowledge, no RAM traffic.
        step(); cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h4000;
        step(); cctrans[1] = 1'b1;
        step(); @(negedge CLK);
        chk("t5_ack_dwait", 32'(dwait), 2); chk("t5_ack_ccinv", 32'(ccinv), 2);
        chk("t5_ack_ram", 32'({ramREN, ramWEN}), 0);
        step(); quiet();
        @(negedge CLK); chk("t5_after_dwait", 32'(dwait), 3);

        // Stalled RAM in LD, then reset mid-transaction.
        step(); dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h5000; ramstate = 2'd1;
        step(); cctrans[1] = 1'b1;
        step(); cctrans[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t6_busy_dwait", 32'(dwait), 3); chk("t6_busy_addr", ramaddr, 32'h5000);
            step();
        end
        ramstate = 2'd3;
        @(negedge CLK); chk("t6_err_dwait", 32'(dwait), 3); chk("t6_err_ren", 32'(ramREN), 1);
        step(); ramstate = 2'd2;
        @(negedge CLK); chk("t6_acc_dwait", 32'(dwait), 2);
        step(); ramstate = 2'd1;
        #2 nRST = 1'b0;
        #1;
        chk("t6_rst_ccwait", 32'(ccwait), 0); chk("t6_rst_ren", 32'(ramREN), 0);
        chk("t6_rst_dwait", 32'(dwait), 3); chk("t6_rst_addr", ramaddr, 0);
        @(negedge CLK); #1 nRST = 1'b1;
        quiet();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            step();
            iREN = 2'($urandom_range(0, 3));
            for (int c = 0; c < 2; c++) begin
                dWEN[c]    = ($urandom_range(0, 3) == 0);
                dREN[c]    = 1'($urandom_range(0, 1));
                cctrans[c] = ($urandom_range(0, 2) == 0);
                ccwrite[c] = 1'($urandom_range(0, 1));
                daddr[c]   = 32'($urandom_range(0, 16383)) << 2;
                iaddr[c]   = 32'($urandom_range(0, 16383)) << 2;
                dstore[c]  = $urandom;
            end
            r = $urandom_range(0, 7);
            ramstate = (r < 4) ? 2'd2 : (r == 4) ? 2'd0 : (r == 5) ? 2'd3 : 2'd1;
            if ($urandom_range(0, 399) == 0) begin
                #2 nRST = 1'b0;
                #1 nRST = 1'b1;
            end
        end

        @(negedge CLK);
        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
